// File: rtl/sudoku_board_ctrl.sv
// Sudoku game-state stage: loads a puzzle from a synchronous ROM, holds the
// live board and cursor, applies keyboard commands and flags completion.
// Feeds the board-numbers draw stage directly.
module sudoku_board_ctrl #(
  parameter int ROM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2:0]              board_size_in,
  input  logic                    cmd_valid,
  input  logic [2:0]              cmd,
  input  logic [4:0]              cmd_digit,
  output logic [7:0]              rom_addr,
  input  logic [9:0]              rom_data,
  output logic [15:0][15:0][5:0]  board,
  output logic [3:0]              selection_x,
  output logic [3:0]              selection_y,
  output logic [2:0]              board_size,
  output logic                    is_game_on,
  output logic                    busy,
  output logic                    solved
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PLAY, ST_SOLVED} state_t;

  localparam logic [2:0] CMD_UP    = 3'd0;
  localparam logic [2:0] CMD_DOWN  = 3'd1;
  localparam logic [2:0] CMD_LEFT  = 3'd2;
  localparam logic [2:0] CMD_RIGHT = 3'd3;
  localparam logic [2:0] CMD_SET   = 3'd4;
  localparam logic [2:0] CMD_CLEAR = 3'd5;

  state_t                   state_r, state_n;
  logic [15:0][15:0][4:0]   sol_r;
  logic [8:0]               mism_r;
  logic [8:0]               load_cnt_r;
  logic [7:0]               addr_d_r;

  logic                     start_ok_s;
  logic                     play_cmd_s;
  logic [4:0]               sz_s;
  logic [3:0]               sz_m1_s;
  logic [8:0]               last_s;
  logic [7:0]               nxt_addr_s;
  logic [4:0]               cap_given_s;
  logic [4:0]               cap_sol_s;
  logic [5:0]               cur_cell_s;
  logic [4:0]               cur_sol_s;
  logic                     edit_we_s;
  logic [4:0]               edit_val_s;
  logic                     was_match_s;
  logic                     now_match_s;

  assign start_ok_s  = start && ((board_size_in == 3'd2) || (board_size_in == 3'd3) ||
                                 (board_size_in == 3'd4));
  assign play_cmd_s  = cmd_valid && (state_r == ST_PLAY) && !start_ok_s;
  assign cap_given_s = rom_data[9:5];
  assign cap_sol_s   = rom_data[4:0];
  assign cur_cell_s  = board[selection_y][selection_x];
  assign cur_sol_s   = sol_r[selection_y][selection_x];
  assign was_match_s = (cur_cell_s[5:1] == cur_sol_s);
  assign now_match_s = (edit_val_s == cur_sol_s);

  // Side length S, S-1 and the final LOAD count S*S for the latched box size.
  always_comb begin
    case (board_size)
      3'd2: begin sz_s = 5'd4;  sz_m1_s = 4'd3;  last_s = 9'd16;  end
      3'd4: begin sz_s = 5'd16; sz_m1_s = 4'd15; last_s = 9'd256; end
      default: begin sz_s = 5'd9; sz_m1_s = 4'd8; last_s = 9'd81; end
    endcase
  end

  // Row-major walk over the active S x S region of the ROM.
  always_comb begin
    if (rom_addr[3:0] == sz_m1_s) begin
      nxt_addr_s = {rom_addr[7:4] + 4'd1, 4'd0};
    end else begin
      nxt_addr_s = {rom_addr[7:4], rom_addr[3:0] + 4'd1};
    end
  end

  // Decide whether a set/clear edits the cell under the cursor, and to what.
  always_comb begin
    edit_we_s  = 1'b0;
    edit_val_s = cur_cell_s[5:1];
    if (play_cmd_s) begin
      case (cmd)
        CMD_SET: begin
          if (!cur_cell_s[0] && (cmd_digit != 5'd0) && (cmd_digit <= sz_s)) begin
            edit_we_s  = 1'b1;
            edit_val_s = cmd_digit;
          end else begin
            edit_we_s  = 1'b0;
          end
        end
        CMD_CLEAR: begin
          if (!cur_cell_s[0]) begin
            edit_we_s  = 1'b1;
            edit_val_s = 5'd0;
          end else begin
            edit_we_s  = 1'b0;
          end
        end
        default: edit_we_s = 1'b0;
      endcase
    end else begin
      edit_we_s = 1'b0;
    end
  end

  // Next game state; an accepted start always (re)enters LOAD.
  always_comb begin
    state_n = state_r;
    if (start_ok_s) begin
      state_n = ST_LOAD;
    end else begin
      case (state_r)
        ST_IDLE:   state_n = ST_IDLE;
        ST_LOAD:   state_n = (load_cnt_r == last_s) ? ST_PLAY : ST_LOAD;
        ST_PLAY:   state_n = (mism_r == 9'd0) ? ST_SOLVED : ST_PLAY;
        ST_SOLVED: state_n = ST_SOLVED;
        default:   state_n = ST_IDLE;
      endcase
    end
  end

  // State register and status flags, registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      busy       <= 1'b0;
      is_game_on <= 1'b0;
      solved     <= 1'b0;
    end else begin
      state_r    <= state_n;
      busy       <= (state_n == ST_LOAD);
      is_game_on <= (state_n == ST_PLAY) || (state_n == ST_SOLVED);
      solved     <= (state_n == ST_SOLVED);
    end
  end

  // Board, solution, cursor, ROM address walk and mismatch bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      board       <= '0;
      sol_r       <= '0;
      mism_r      <= 9'd0;
      selection_x <= 4'd0;
      selection_y <= 4'd0;
      board_size  <= 3'd3;
      rom_addr    <= 8'd0;
      addr_d_r    <= 8'd0;
      load_cnt_r  <= 9'd0;
    end else if (start_ok_s) begin
      board       <= '0;
      sol_r       <= '0;
      mism_r      <= 9'd0;
      selection_x <= 4'd0;
      selection_y <= 4'd0;
      board_size  <= board_size_in;
      rom_addr    <= 8'd0;
      addr_d_r    <= 8'd0;
      load_cnt_r  <= 9'd0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          load_cnt_r <= load_cnt_r + 9'd1;
          addr_d_r   <= rom_addr;
          // Hold the last address so the bus never leaves the active region.
          if (load_cnt_r < last_s - 9'd1) begin
            rom_addr <= nxt_addr_s;
          end
          // Data returned this cycle belongs to the address of the previous one.
          if (load_cnt_r >= 9'(ROM_LATENCY)) begin
            board[addr_d_r[7:4]][addr_d_r[3:0]] <= {cap_given_s, cap_given_s != 5'd0};
            sol_r[addr_d_r[7:4]][addr_d_r[3:0]] <= cap_sol_s;
            if (cap_given_s != cap_sol_s) begin
              mism_r <= mism_r + 9'd1;
            end
          end
        end
        ST_PLAY: begin
          if (play_cmd_s) begin
            case (cmd)
              CMD_UP:    selection_y <= (selection_y == 4'd0) ? sz_m1_s : selection_y - 4'd1;
              CMD_DOWN:  selection_y <= (selection_y == sz_m1_s) ? 4'd0 : selection_y + 4'd1;
              CMD_LEFT:  selection_x <= (selection_x == 4'd0) ? sz_m1_s : selection_x - 4'd1;
              CMD_RIGHT: selection_x <= (selection_x == sz_m1_s) ? 4'd0 : selection_x + 4'd1;
              default: ;
            endcase
          end
          if (edit_we_s) begin
            board[selection_y][selection_x][5:1] <= edit_val_s;
            if (was_match_s && !now_match_s) begin
              mism_r <= mism_r + 9'd1;
            end else if (!was_match_s && now_match_s) begin
              mism_r <= mism_r - 9'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_board_ctrl.sv
// Self-checking bench for sudoku_board_ctrl: ROM model, address and command
// scoreboards, and a behavioural board/cursor model.
module tb_sudoku_board_ctrl;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [2:0]             board_size_in;
  logic                   cmd_valid;
  logic [2:0]             cmd;
  logic [4:0]             cmd_digit;
  logic [7:0]             rom_addr;
  logic [9:0]             rom_data;
  logic [15:0][15:0][5:0] board;
  logic [3:0]             selection_x;
  logic [3:0]             selection_y;
  logic [2:0]             board_size;
  logic                   is_game_on;
  logic                   busy;
  logic                   solved;

  sudoku_board_ctrl #(.ROM_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .start(start), .board_size_in(board_size_in),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_digit(cmd_digit),
    .rom_addr(rom_addr), .rom_data(rom_data), .board(board),
    .selection_x(selection_x), .selection_y(selection_y), .board_size(board_size),
    .is_game_on(is_game_on), .busy(busy), .solved(solved)
  );

  always #5 clk = ~clk;

  // Synchronous puzzle ROM, one cycle of read latency.
  logic [9:0] rom_mem [256];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int n_pass = 0;
  int n_total = 0;
  logic [7:0]  addr_q[$];
  logic [31:0] exp_q[$];

  // Reference model of the game.
  int         m_s;
  int         m_x, m_y;
  bit         m_play, m_solved;
  logic [4:0] m_val  [16][16];
  logic       m_lock [16][16];
  logic [4:0] m_sol  [16][16];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] sol_val(int n, int y, int x);
    if (n == 2) begin
      case (y * 4 + x)
        0: return 5'd1;  1: return 5'd2;  2: return 5'd4;  3: return 5'd3;
        4: return 5'd3;  5: return 5'd4;  6: return 5'd1;  7: return 5'd2;
        8: return 5'd4;  9: return 5'd3;  10: return 5'd2; 11: return 5'd1;
        12: return 5'd2; 13: return 5'd1; 14: return 5'd3; default: return 5'd4;
      endcase
    end
    return 5'(((n * (y % n) + y / n + x) % (n * n)) + 1);
  endfunction

  // mode 0: givens only at (0,0) and (3,3); mode 1: givens on the diagonal.
  task automatic fill_rom(input int n, input int mode);
    logic [4:0] sv, gv;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        if (y < n * n && x < n * n) begin
          sv = sol_val(n, y, x);
          if (mode == 0) gv = ((y == 0 && x == 0) || (y == 3 && x == 3)) ? sv : 5'd0;
          else           gv = (x == y) ? sv : 5'd0;
          rom_mem[y * 16 + x] = {gv, sv};
        end else begin
          rom_mem[y * 16 + x] = 10'h3FF;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        m_val[y][x] = 5'd0; m_lock[y][x] = 1'b0; m_sol[y][x] = 5'd0;
      end
    m_x = 0; m_y = 0; m_play = 0; m_solved = 0; m_s = 9;
  endtask

  task automatic model_load(input int n);
    model_reset();
    m_s = n * n;
    for (int y = 0; y < m_s; y++)
      for (int x = 0; x < m_s; x++) begin
        m_val[y][x]  = rom_mem[y * 16 + x][9:5];
        m_lock[y][x] = (rom_mem[y * 16 + x][9:5] != 5'd0);
        m_sol[y][x]  = rom_mem[y * 16 + x][4:0];
      end
    m_play = 1;
  endtask

  function automatic bit all_match();
    for (int y = 0; y < m_s; y++)
      for (int x = 0; x < m_s; x++)
        if (m_val[y][x] != m_sol[y][x]) return 0;
    return 1;
  endfunction

  task automatic check_board(input string tag);
    int bad = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        if (board[y][x] !== {m_val[y][x], m_lock[y][x]}) bad++;
    check(tag, bad, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check_board({tag, "_board"});
    check({tag, "_sel"}, {selection_y, selection_x}, 0);
    check({tag, "_size"}, board_size, 3);
    check({tag, "_flags"}, {is_game_on, busy, solved}, 0);
    check({tag, "_addr"}, rom_addr, 0);
  endtask

  // Pulse start; a legal size refills the expected-address scoreboard.
  task automatic pulse_start(input int n);
    int s = n * n;
    board_size_in = 3'(n);
    start = 1'b1;
    if (n >= 2 && n <= 4) begin
      addr_q.delete();
      for (int k = 0; k < s * s; k++) addr_q.push_back({4'(k / s), 4'(k % s)});
    end
    tick();
    start = 1'b0;
  endtask

  // Follow LOAD to its end, comparing each issued address; bounded wait.
  task automatic run_load(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 300 && busy; i++) begin
      busy_cycles++;
      if (addr_q.size() > 0) check("rom_addr", rom_addr, addr_q.pop_front());
      tick();
    end
  endtask

  task automatic do_load(input int n, input int mode, input string tag);
    int bc;
    fill_rom(n, mode);
    pulse_start(n);
    run_load(bc);
    check({tag, "_busy_len"}, bc, n * n * n * n + 1);
    check({tag, "_addr_left"}, addr_q.size(), 0);
    model_load(n);
    check_board({tag, "_board"});
    check({tag, "_state"}, {is_game_on, busy, selection_y, selection_x, board_size}, {1'b1, 1'b0, 8'd0, 3'(n)});
  endtask

  // Drive one command, predict its effect, compare after the clock edge.
  task automatic do_cmd(input logic [2:0] c, input logic [4:0] d, input string tag);
    cmd = c; cmd_digit = d; cmd_valid = 1'b1;
    if (m_play && !m_solved) begin
      case (c)
        3'd0: m_y = (m_y == 0) ? m_s - 1 : m_y - 1;
        3'd1: m_y = (m_y == m_s - 1) ? 0 : m_y + 1;
        3'd2: m_x = (m_x == 0) ? m_s - 1 : m_x - 1;
        3'd3: m_x = (m_x == m_s - 1) ? 0 : m_x + 1;
        3'd4: if (!m_lock[m_y][m_x] && d != 5'd0 && int'(d) <= m_s) m_val[m_y][m_x] = d;
        3'd5: if (!m_lock[m_y][m_x]) m_val[m_y][m_x] = 5'd0;
        default: ;
      endcase
    end
    exp_q.push_back({17'd0, m_solved, 4'(m_y), 4'(m_x), m_val[m_y][m_x], m_lock[m_y][m_x]});
    tick();
    cmd_valid = 1'b0;
    check(tag, {17'd0, solved, selection_y, selection_x, board[m_y][m_x]}, exp_q.pop_front());
  endtask

  initial begin
    int bc;
    bit done;
    rst = 1'b1; start = 1'b0; board_size_in = 3'd3;
    cmd_valid = 1'b0; cmd = 3'd0; cmd_digit = 5'd0;
    fill_rom(2, 0);
    model_reset();
    tick(); tick();
    rst = 1'b0;

    // Reset state, and commands ignored in IDLE.
    check_reset_state("rst");
    do_cmd(3'd3, 5'd0, "idle_right");

    // Load with N = 2.
    do_load(2, 0, "load2");
    check("cell00", board[0][0], 6'h03);
    check("cell33", board[3][3], 6'h09);
    check("cell01", board[0][1], 6'h00);
    check("cell55", board[5][5], 6'h00);

    // Illegal size start is ignored.
    board_size_in = 3'd5; start = 1'b1; tick(); start = 1'b0;
    check("bad_size", {is_game_on, busy, board_size}, {1'b1, 1'b0, 3'd2});
    check_board("bad_size_board");

    // Cursor wrap and edit rules, N = 3.
    do_load(3, 1, "load3");
    do_cmd(3'd2, 5'd0, "wrap_left");
    do_cmd(3'd0, 5'd0, "wrap_up");
    do_cmd(3'd3, 5'd0, "wrap_right");
    do_cmd(3'd1, 5'd0, "wrap_down");
    do_cmd(3'd4, 5'd7, "set_locked");
    do_cmd(3'd5, 5'd0, "clear_locked");
    do_cmd(3'd3, 5'd0, "move_right");
    do_cmd(3'd4, 5'd0, "set_zero");
    do_cmd(3'd4, 5'd10, "set_ten");
    do_cmd(3'd4, 5'd5, "set_five");
    do_cmd(3'd5, 5'd0, "clear");
    do_cmd(3'd4, 5'd9, "set_nine");
    do_cmd(3'd6, 5'd3, "noop_cmd");

    // Solve N = 2, including wrong writes and corrections.
    do_load(2, 0, "load_solve");
    done = 0;
    for (int y = 0; y < 4 && !done; y++) begin
      for (int x = 0; x < 4 && !done; x++) begin
        if (!m_lock[m_y][m_x]) begin
          if (m_y == 0 && m_x == 1) do_cmd(3'd4, (m_sol[m_y][m_x] % 4) + 5'd1, "solve_wrong");
          if (m_y == 1 && m_x == 2) begin
            do_cmd(3'd4, m_sol[m_y][m_x], "solve_set");
            do_cmd(3'd4, (m_sol[m_y][m_x] % 4) + 5'd1, "solve_unmatch");
          end
          do_cmd(3'd4, m_sol[m_y][m_x], "solve_set");
          if (all_match()) done = 1;
        end
        if (!done) do_cmd(3'd3, 5'd0, "solve_move");
      end
      if (!done) do_cmd(3'd1, 5'd0, "solve_down");
    end
    check("solve_done", done, 1);
    tick();
    check("solved_rise", solved, 1);
    m_solved = 1;
    do_cmd(3'd4, (m_sol[m_y][m_x] % 4) + 5'd1, "solved_set_ignored");
    do_cmd(3'd2, 5'd0, "solved_move_ignored");

    // Restart during LOAD.
    fill_rom(3, 1);
    pulse_start(3);
    for (int i = 0; i < 40; i++) begin
      if (addr_q.size() > 0) check("rom_addr_pre", rom_addr, addr_q.pop_front());
      tick();
    end
    fill_rom(2, 0);
    pulse_start(2);
    check("restart_busy", busy, 1);
    run_load(bc);
    check("restart_busy_len", bc, 17);
    model_load(2);
    check_board("restart_board");

    // Reset in the middle of LOAD.
    fill_rom(3, 1);
    pulse_start(3);
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
    check_reset_state("rst_mid");
    tick();
    check("rst_mid_idle", {is_game_on, busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sudoku_board_ctrl.md
Name: sudoku_board_ctrl

Overview:
- Game-state stage directly upstream of the board-numbers draw stage.
- Loads a puzzle (givens plus solution) from a synchronous puzzle ROM.
- Holds the live board array and the cursor, and applies keyboard commands (move, set digit, clear).
- Flags completion when every cell matches the solution.
- Outputs drive the draw stage's board, selection_x/y, board_size and is_game_on inputs directly.

Parameters:
- ROM_LATENCY, 1, puzzle ROM read latency in clk cycles; only 1 is supported.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse; (re)load the puzzle with board_size_in
- board_size_in  in  3  box dimension N; legal values 2, 3, 4
- cmd_valid  in  1  one-cycle command strobe
- cmd  in  3  0=up, 1=down, 2=left, 3=right, 4=set, 5=clear; 6 and 7 are no-ops
- cmd_digit  in  5  digit for set
- rom_addr  out  8  puzzle ROM address, {y[3:0], x[3:0]}
- rom_data  in  10  [9:5] given value (0 = empty cell), [4:0] solution value
- board  out  6x16x16  board[y][x] = {value[4:0], locked}; value 0 = empty
- selection_x  out  4  cursor column
- selection_y  out  4  cursor row
- board_size  out  3  latched N
- is_game_on  out  1  high in PLAY and SOLVED
- busy  out  1  high in LOAD
- solved  out  1  high in SOLVED

Behaviour:
- Reset: every board cell 0; selection_x = selection_y = 0; board_size = 3; is_game_on = busy = solved = 0; rom_addr = 0; mismatch counter 0; state IDLE.
- Definitions: S = N*N (4, 9 or 16). All outputs are registered.
- start is accepted in any state only when board_size_in ∈ {2, 3, 4}; otherwise it is ignored.
- start accepted, next cycle:
  - latch board_size;
  - clear all 256 cells and the mismatch counter;
  - cursor to (0,0);
  - enter LOAD.
- start during LOAD aborts the current load and restarts it cleanly.
- LOAD addressing:
  - The address counter walks y = 0..S-1 (outer) and x = 0..S-1 (inner), one address per cycle.
  - The rom_data for the address issued in cycle k is captured in cycle k+1.
  - Captured cell: value = given, locked = (given != 0).
  - A separate 16x16x5 solution array stores the solution value.
  - Mismatch counter (9 bits) increments for each cell whose given != solution.
- LOAD timing: busy rises the cycle after start. LOAD lasts S*S + 1 cycles (17, 82, 257); the last capture lands in the final LOAD cycle. The next state is PLAY.
- Cells with x >= S or y >= S stay 0 for the whole game.
- IDLE: commands are ignored and is_game_on = 0.
- PLAY, moves (one command per cmd_valid pulse, takes effect the next cycle):
  - up: y = (y == 0) ? S-1 : y-1
  - down: y = (y == S-1) ? 0 : y+1
  - left / right: same wrap rule on x
- PLAY, set:
  - Ignored if the cell is locked, cmd_digit == 0, or cmd_digit > S.
  - Otherwise value <= cmd_digit.
- PLAY, clear: ignored if the cell is locked; otherwise value <= 0.
- Mismatch update on set/clear:
  - Counter += 1 when the cell goes from match to mismatch.
  - Counter -= 1 when it goes from mismatch to match.
  - Otherwise unchanged.
  - Setting the value the cell already holds changes nothing.
- The locked bit never changes in PLAY.
- PLAY → SOLVED when the counter is 0; this is checked every cycle, so a puzzle with no empty cells goes to SOLVED one cycle after LOAD.
- SOLVED: solved = 1; is_game_on stays 1; all commands are ignored; only start or rst leaves this state.
- cmd_valid is ignored in LOAD and in the same cycle as an accepted start (start wins).
- rst mid-LOAD returns everything to reset values; no partial board survives.

Test Plan:
- Reset:
  - Assert rst for 2 cycles → all board cells 0, selection (0,0), board_size = 3, is_game_on = busy = solved = 0.
  - Then apply cmd_valid with cmd = 3 → selection unchanged.
- Load, N = 2:
  - ROM model has givens at (0,0) = 1 and (3,3) = 4; the solution is a valid 4x4 grid; start with board_size_in = 2.
  - busy is high for exactly 17 cycles.
  - rom_addr covers 0x00..0x33 with x < 4.
  - Afterwards board[0][0] = {1,1}, board[3][3] = {4,1}, board[0][1] = 0, board[5][5] = 0, is_game_on = 1.
- Cursor wrap, N = 3:
  - From (0,0), left → x = 8; up → y = 8; right → x = 0; down → y = 0.
- Edit rules:
  - set 7 on a locked cell → cell unchanged.
  - set 0 or set 10 with N = 3 → ignored.
  - set 5 on an empty cell → value 5, locked 0.
  - clear → value 0.
- Solve, N = 2:
  - Set every empty cell to its solution value, including one wrong write followed by a correction.
  - solved rises exactly 1 cycle after the last correct write.
  - A later set command is ignored and solved stays 1.
- Restart:
  - start during LOAD halfway → busy stays high, the address restarts at 0x00, and the board equals a clean load.
  - start with board_size_in = 5 → ignored.
  - rst mid-LOAD → reset values.
